// File: rtl/quad_pkg.sv
// Shared types and constants for the quadrature decoder: FSM states,
// the 2-bit phase encodings {a, b}, direction constants, and the
// transition classifier used by the decode stage.
package quad_pkg;

  // Control FSM: PRIME captures the starting phase, TRACK decodes motion.
  typedef enum logic {
    PRIME = 1'b0,
    TRACK = 1'b1
  } state_e;

  // Phase encodings, written as {a, b}.
  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_01 = 2'b01;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_10 = 2'b10;

  // Direction flag values.
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Result of comparing the previous phase against the current one.
  typedef enum logic [1:0] {
    MOVE_NONE = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    MOVE_BAD  = 2'd3
  } move_e;

  // Successor of a phase in the up direction: 00 -> 01 -> 11 -> 10 -> 00.
  function automatic logic [1:0] next_up(input logic [1:0] ph);
    logic [1:0] nxt;
    case (ph)
      PH_00:   nxt = PH_01;
      PH_01:   nxt = PH_11;
      PH_11:   nxt = PH_10;
      default: nxt = PH_00;
    endcase
    return nxt;
  endfunction

  // Classify one prev -> cur transition. Gray-coded phases change one bit
  // per legal step, so two changed bits can only be a missed step.
  function automatic move_e classify(input logic [1:0] prev, input logic [1:0] cur);
    move_e mv;
    if (cur == prev) begin
      mv = MOVE_NONE;
    end else if ((cur ^ prev) == 2'b11) begin
      mv = MOVE_BAD;
    end else if (cur == next_up(prev)) begin
      mv = MOVE_UP;
    end else begin
      mv = MOVE_DOWN;
    end
    return mv;
  endfunction

endpackage : quad_pkg

// File: rtl/sync2.sv
// Multi-flop synchronizer for one asynchronous input bit. STAGES must be
// at least 2; the chain clears to 0 on reset.
module sync2 #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  // Shift the raw input through the chain; the MSB is the usable copy.
  // NOTE: the synchronizer flops are reset too, so a freshly released
  // decoder sees a known 0 rather than X until real samples arrive.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule : sync2

// File: rtl/quad_decoder.sv
// Quadrature decoder: synchronizes phases a/b, tracks the previous phase,
// counts legal steps up or down into a wrapping position register, and
// latches a sticky error on any two-bit jump. All outputs are registered.
module quad_decoder
  import quad_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             a,
  input  logic             b,
  input  logic             en,
  input  logic             zero,
  input  logic             err_clr,
  output logic [WIDTH-1:0] pos,
  output logic             dir,
  output logic             step,
  output logic             err
);

  // PRIME must outlast the synchronizer flush: the chain holds reset zeros
  // for SYNC_STAGES edges, and priming from those would turn a non-zero
  // starting phase into a bogus step or error.
  localparam int CNT_W = $clog2(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0] PRIME_LAST = CNT_W'(SYNC_STAGES);

  logic             a_s;
  logic             b_s;
  logic [1:0]       s;
  move_e            move;

  state_e           state_q;
  logic [CNT_W-1:0] prime_cnt_q;
  logic [1:0]       prev_q;
  logic [WIDTH-1:0] pos_q, pos_d;
  logic             dir_q, dir_d;
  logic             step_q, step_d;
  logic             err_q, err_d;

  sync2 #(.STAGES(SYNC_STAGES)) u_sync_a (
    .clk (clk),
    .clr (clr),
    .d   (a),
    .q   (a_s)
  );

  sync2 #(.STAGES(SYNC_STAGES)) u_sync_b (
    .clk (clk),
    .clr (clr),
    .d   (b),
    .q   (b_s)
  );

  assign s    = {a_s, b_s};
  assign move = classify(prev_q, s);

  // Next values of the outputs from the decoded move and the clear inputs.
  // NOTE: every output gets its hold value first so no path through the
  // block leaves a variable unassigned, which would infer a latch.
  always_comb begin
    pos_d  = pos_q;
    dir_d  = dir_q;
    step_d = 1'b0;
    err_d  = err_q;

    // err_clr is applied first so a coincident illegal move overrides it.
    if (err_clr) begin
      err_d = 1'b0;
    end

    if (state_q == TRACK) begin
      case (move)
        MOVE_UP: begin
          if (en) begin
            step_d = 1'b1;
            dir_d  = DIR_UP;
            pos_d  = pos_q + WIDTH'(1);
          end
        end
        MOVE_DOWN: begin
          if (en) begin
            step_d = 1'b1;
            dir_d  = DIR_DOWN;
            pos_d  = pos_q - WIDTH'(1);
          end
        end
        MOVE_BAD: begin
          err_d = 1'b1;
        end
        default: ;
      endcase
    end

    // zero beats a coincident step on pos only; step/dir still report it.
    if (zero) begin
      pos_d = '0;
    end
  end

  // Control FSM plus output registers; prev follows s on every edge.
  // NOTE: non-blocking assignments keep all registers updating from the
  // same pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q     <= PRIME;
      prime_cnt_q <= '0;
      prev_q      <= PH_00;
      pos_q       <= '0;
      dir_q       <= DIR_DOWN;
      step_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      prev_q <= s;
      pos_q  <= pos_d;
      dir_q  <= dir_d;
      step_q <= step_d;
      err_q  <= err_d;
      case (state_q)
        PRIME: begin
          if (prime_cnt_q == PRIME_LAST) begin
            state_q <= TRACK;
          end else begin
            prime_cnt_q <= prime_cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= TRACK;
        end
      endcase
    end
  end

  assign pos  = pos_q;
  assign dir  = dir_q;
  assign step = step_q;
  assign err  = err_q;

endmodule : quad_decoder

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder. Stimulus pushes the expected step
// (edge of arrival, pos, dir) into a queue; a monitor pops one entry for
// every step pulse the DUT shows. Static state is checked directly.
module tb_quad_decoder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         clr = 1'b0;
  logic         a = 1'b0;
  logic         b = 1'b0;
  logic         en = 1'b0;
  logic         zero = 1'b0;
  logic         err_clr = 1'b0;
  logic [W-1:0] pos;
  logic         dir;
  logic         step;
  logic         err;

  quad_decoder #(.WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk     (clk),
    .clr     (clr),
    .a       (a),
    .b       (b),
    .en      (en),
    .zero    (zero),
    .err_clr (err_clr),
    .pos     (pos),
    .dir     (dir),
    .step    (step),
    .err     (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           cyc;
    logic [W-1:0] pos;
    logic         dir;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec   = 0;
  int   n_err   = 0;
  int   n_steps = 0;

  // Up-direction phase order {a, b}.
  logic [1:0] up_seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Drive a new phase just after a falling edge; the pulse is expected
  // three rising edges later (two sync stages plus the decode register).
  task automatic do_step(input logic [1:0] ab, input logic push,
                         input logic [W-1:0] epos, input logic edir);
    @(negedge clk);
    {a, b} = ab;
    if (push) exp_q.push_back('{cyc + 3, epos, edir});
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard monitor: each step pulse must match the head of the queue.
  always begin
    @(negedge clk);
    if (clr && step === 1'b1) begin
      n_steps++;
      if (exp_q.size() == 0) begin
        check("unexpected_step", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("step_cycle", cyc, e.cyc);
        check("step_pos", {24'd0, pos}, {24'd0, e.pos});
        check("step_dir", {31'd0, dir}, {31'd0, e.dir});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, asserted from time zero.
    #1;
    check("rst_pos", {24'd0, pos}, 32'd0);
    check("rst_dir", {31'd0, dir}, 32'd0);
    check("rst_step", {31'd0, step}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);

    // Release with a = b = 1: priming must not count or flag.
    a = 1'b1; b = 1'b1;
    settle(3);
    clr = 1'b1;
    settle(10);
    check("prime11_pos", {24'd0, pos}, 32'd0);
    check("prime11_err", {31'd0, err}, 32'd0);
    check("prime11_steps", n_steps, 0);

    // Re-reset with the phases at 00 for counting tests.
    @(negedge clk);
    clr = 1'b0; a = 1'b0; b = 1'b0;
    settle(2);
    clr = 1'b1;
    settle(10);
    en = 1'b1;

    // Twelve up steps from 00.
    for (int i = 0; i < 12; i++) begin
      do_step(up_seq[(i + 1) % 4], 1'b1, W'(i + 1), 1'b1);
    end
    settle(5);
    check("up12_pos", {24'd0, pos}, 32'd12);
    check("up12_dir", {31'd0, dir}, 32'd1);
    check("up12_steps", n_steps, 12);

    // Zero, then wrap down below 0 and back up.
    @(negedge clk); zero = 1'b1;
    @(negedge clk); zero = 1'b0;
    settle(2);
    check("zero_pos", {24'd0, pos}, 32'd0);
    do_step(2'b10, 1'b1, 8'd255, 1'b0);
    settle(5);
    check("wrap_dn_pos", {24'd0, pos}, 32'd255);
    check("wrap_dn_dir", {31'd0, dir}, 32'd0);
    do_step(2'b00, 1'b1, 8'd0, 1'b1);
    settle(5);
    check("wrap_up_pos", {24'd0, pos}, 32'd0);

    // Illegal 00 -> 11.
    do_step(2'b11, 1'b0, 8'd0, 1'b0);
    settle(5);
    check("bad_err", {31'd0, err}, 32'd1);
    check("bad_pos", {24'd0, pos}, 32'd0);
    check("bad_dir", {31'd0, dir}, 32'd1);
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    settle(1);
    check("errclr_err", {31'd0, err}, 32'd0);
    // Move to 01 uncounted, then 01 -> 10 coincident with err_clr.
    @(negedge clk); en = 1'b0;
    do_step(2'b01, 1'b0, 8'd0, 1'b0);
    settle(5);
    check("en0_dn_pos", {24'd0, pos}, 32'd0);
    check("en0_dn_err", {31'd0, err}, 32'd0);
    en = 1'b1;
    do_step(2'b10, 1'b0, 8'd0, 1'b0);
    @(negedge clk);
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    settle(2);
    check("bad_wins_err", {31'd0, err}, 32'd1);
    check("bad_wins_pos", {24'd0, pos}, 32'd0);
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;

    // Enable gating: four uncounted up steps, then two counted.
    en = 1'b0;
    do_step(2'b00, 1'b0, 8'd0, 1'b0);
    do_step(2'b01, 1'b0, 8'd0, 1'b0);
    do_step(2'b11, 1'b0, 8'd0, 1'b0);
    do_step(2'b10, 1'b0, 8'd0, 1'b0);
    settle(5);
    check("en0_pos", {24'd0, pos}, 32'd0);
    en = 1'b1;
    do_step(2'b00, 1'b1, 8'd1, 1'b1);
    do_step(2'b01, 1'b1, 8'd2, 1'b1);
    settle(5);
    check("en1_pos", {24'd0, pos}, 32'd2);
    check("en1_err", {31'd0, err}, 32'd0);
    check("en1_steps", n_steps, 16);

    // Reach 5, then zero coincident with an up step.
    do_step(2'b11, 1'b1, 8'd3, 1'b1);
    do_step(2'b10, 1'b1, 8'd4, 1'b1);
    do_step(2'b00, 1'b1, 8'd5, 1'b1);
    settle(5);
    check("pos5", {24'd0, pos}, 32'd5);
    do_step(2'b01, 1'b1, 8'd0, 1'b1);
    @(negedge clk);
    @(negedge clk); zero = 1'b1;
    @(negedge clk); zero = 1'b0;
    settle(3);
    check("zero_step_pos", {24'd0, pos}, 32'd0);
    check("zero_step_dir", {31'd0, dir}, 32'd1);
    check("zero_step_steps", n_steps, 20);

    // Build non-zero state, then assert clr while a step pulse is high.
    do_step(2'b11, 1'b1, 8'd1, 1'b1);
    settle(5);
    do_step(2'b00, 1'b0, 8'd0, 1'b0);
    settle(5);
    check("pre_rst_err", {31'd0, err}, 32'd1);
    check("pre_rst_pos", {24'd0, pos}, 32'd1);
    do_step(2'b01, 1'b0, 8'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_step", {31'd0, step}, 32'd1);
    check("pre_rst_pos2", {24'd0, pos}, 32'd2);
    #1 clr = 1'b0;
    #1;
    check("mid_rst_pos", {24'd0, pos}, 32'd0);
    check("mid_rst_dir", {31'd0, dir}, 32'd0);
    check("mid_rst_step", {31'd0, step}, 32'd0);
    check("mid_rst_err", {31'd0, err}, 32'd0);
    settle(3);
    clr = 1'b1;
    settle(10);
    check("reprime_pos", {24'd0, pos}, 32'd0);
    check("reprime_err", {31'd0, err}, 32'd0);
    do_step(2'b11, 1'b1, 8'd1, 1'b1);
    settle(5);
    check("post_rst_pos", {24'd0, pos}, 32'd1);
    check("post_rst_dir", {31'd0, dir}, 32'd1);
    check("final_steps", n_steps, 22);
    check("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_quad_decoder

// File: doc/quad_decoder.md
QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 Parameter WIDTH, default 8: width of the position count.
REQ-002 Parameter SYNC_STAGES, default 2, minimum 2: synchronizer depth on inputs a and b.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 clr  input  1  reset, asynchronous, active-low.
REQ-005 a  input  1  quadrature phase A, asynchronous to clk.
REQ-006 b  input  1  quadrature phase B, asynchronous to clk.
REQ-007 en  input  1  count enable, synchronous.
REQ-008 zero  input  1  synchronous position clear.
REQ-009 err_clr  input  1  synchronous clear of err.
REQ-010 pos  output  WIDTH  signed-agnostic position count, modulo 2^WIDTH.
REQ-011 dir  output  1  direction of last legal step: 1 = up, 0 = down.
REQ-012 step  output  1  one-cycle pulse per legal counted transition.
REQ-013 err  output  1  sticky illegal-transition flag.

Function
REQ-014 a and b SHALL each pass through a SYNC_STAGES-flop synchronizer; all decoding uses synchronized values s = {a_s, b_s}.
REQ-015 Control SHALL be a two-state FSM: PRIME, then TRACK; PRIME loads prev = s without counting or flagging, then moves to TRACK on the next edge.
REQ-016 In TRACK, prev SHALL update to s every cycle, regardless of en.
REQ-017 Up sequence is 00->01->11->10->00; each such prev->s transition SHALL be a legal up step.
REQ-018 The reverse sequence 00->10->11->01->00 SHALL be a legal down step.
REQ-019 s == prev: no action; step = 0; pos, dir, err held.
REQ-020 Both bits changing in one cycle SHALL set err and leave pos, dir, step unchanged.
REQ-021 A legal step with en = 1 SHALL do all of: pulse step for exactly one cycle, set dir, and change pos by +1 (up) or -1 (down).
REQ-022 A legal step with en = 0 SHALL leave pos, dir and step unchanged; illegal detection remains active.
REQ-023 pos SHALL wrap: all-ones + 1 = 0 and 0 - 1 = all-ones, with no flag.
REQ-024 Latency: an input change first sampled at edge 1 SHALL be reflected in pos/step/dir after edge SYNC_STAGES+1 (edge 3 at default).
REQ-025 zero = 1 SHALL set pos to 0 on the next edge; zero wins over a simultaneous step, but step and dir still update.
REQ-026 err_clr = 1 SHALL clear err; a simultaneous illegal transition wins and err stays 1.
REQ-027 All outputs SHALL be registered.

Reset
REQ-028 clr low SHALL immediately force: pos = 0, dir = 0, step = 0, err = 0, synchronizers = 0, prev = 00, FSM = PRIME.
REQ-029 Reset asserted mid-step SHALL discard the pending transition; the first edge after release re-primes from the current inputs without counting.

Structure
REQ-030 Package quad_pkg SHALL hold the FSM state typedef (PRIME, TRACK), the 2-bit phase encodings, and the DIR_UP/DIR_DOWN constants.
REQ-031 Sub-module sync2 (parameterized depth, asynchronous active-low clr) SHALL be instantiated once per phase input.
REQ-032 Target size is 120-400 lines of RTL.

Verification
REQ-033 Reset release with a = b = 1, held 10 cycles -> pos = 0, step never asserted, err = 0.
REQ-034 Twelve up steps from 00, en = 1, WIDTH = 8 -> pos = 12, dir = 1, exactly 12 step pulses, each 3 edges after the input change.
REQ-035 pos = 0, one down step -> pos = 255, dir = 0; then one up step -> pos = 0.
REQ-036 a and b toggled in the same cycle (00->11) -> err = 1 and pos unchanged; err_clr pulsed -> err = 0; err_clr coincident with a new 01->10 -> err stays 1.
REQ-037 en = 0 during 4 up steps, then en = 1 for 2 up steps -> pos = 2, exactly 2 step pulses, no err.
REQ-038 zero coincident with an up step at pos = 5 -> pos = 0, step = 1, dir = 1; clr asserted mid-sequence -> all outputs 0 immediately.
